// File: rtl/jt51_kon_wr_pkg.sv
// rtl/jt51_kon_wr_pkg.sv - shared constants and types for the jt51 key-on write path
//
// Purpose: the key-on register address, the default hold length, FIFO
// geometry, the FSM state type and the {op,ch} entry layout. These are
// shared by jt51_kon_wr, jt51_kon_fifo and the testbench.
package jt51_kon_wr_pkg;

  // CPU-side register that carries key-on/key-off commands
  localparam logic [7:0] KON_REG_ADDR    = 8'h08;
  // One full 32-slot operator sweep
  localparam int         KON_HOLD_CYCLES = 32;
  localparam int         KON_FIFO_DEPTH  = 4;
  localparam int         KON_ENTRY_W     = 7;

  typedef enum logic {
    KON_IDLE = 1'b0,
    KON_HOLD = 1'b1
  } kon_state_t;

  // Packed so that {op,ch} lines up with din[6:0]
  typedef struct packed {
    logic [3:0] op;
    logic [2:0] ch;
  } kon_entry_t;

  // din[7] is not part of the command
  function automatic kon_entry_t kon_decode(input logic [7:0] d);
    return kon_entry_t'(d[6:0]);
  endfunction

endpackage

// File: rtl/jt51_kon_wr_if.sv
// rtl/jt51_kon_wr_if.sv - CPU write bus into the key-on write path
//
// Purpose: groups the CPU bus strobe, address/data select and data byte.
// Signals: write (one-cycle strobe), a0 (0 = address, 1 = data), din[7:0].
// Modports: master drives the bus, slave (jt51_kon_wr) receives it.
interface jt51_kon_wr_if;
  logic       write;
  logic       a0;
  logic [7:0] din;

  modport master (output write, output a0, output din);
  modport slave  (input  write, input  a0, input  din);
endinterface

// File: rtl/jt51_kon_fifo.sv
// rtl/jt51_kon_fifo.sv - small show-ahead FIFO for pending key-on entries
//
// Purpose: in-order queue of key-on entries; dout always presents the
// oldest entry while empty is low.
// Ports: clk, rst (async, active high), push/din, pop/dout, full, empty.
// A push while full and a pop while empty are ignored; push and pop in the
// same cycle are both honoured when the FIFO is not full.
module jt51_kon_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset: nothing reads it while empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jt51_kon_wr.sv
// rtl/jt51_kon_wr.sv - CPU key-on register write path feeding the key-on tracker
//
// Purpose: decodes CPU writes to the key-on register and turns each accepted
// write into an update that holds keyon_ch/keyon_op with up_keyon high for
// HOLD_CYCLES clocks (one operator sweep), separated by at least one low cycle.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   cpu (slave)    - write / a0 / din CPU bus
//   keyon_op[3:0]  - operator mask (bit0 M1, bit1 C1, bit2 M2, bit3 C2)
//   keyon_ch[2:0]  - target channel
//   up_keyon       - update request, high while holding
//   busy           - a key-on write now would be dropped
//   kon_lost       - one-cycle pulse after a dropped key-on write
// Build option: JT51_KON_FIFO_EN queues up to 4 writes in jt51_kon_fifo;
// without it a single pending entry is kept and busy covers the whole hold.
module jt51_kon_wr
  import jt51_kon_wr_pkg::*;
#(
  parameter int HOLD_CYCLES = KON_HOLD_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  jt51_kon_wr_if.slave       cpu,
  output logic [3:0]         keyon_op,
  output logic [2:0]         keyon_ch,
  output logic               up_keyon,
  output logic               busy,
  output logic               kon_lost
);

  localparam logic [4:0] HOLD_LOAD = 5'(HOLD_CYCLES - 1);

  kon_state_t state, next_state;
  logic [7:0] addr;
  logic [4:0] cnt;
  logic       kon_wr, push, pop, avail;
  kon_entry_t wr_entry, head;

  // Decoded against the address latched by an earlier access
  assign kon_wr   = cpu.write & cpu.a0 & (addr == KON_REG_ADDR);
  assign wr_entry = kon_decode(cpu.din);
  assign push     = kon_wr & ~busy;

`ifdef JT51_KON_FIFO_EN
  logic fifo_full, fifo_empty;

  jt51_kon_fifo #(
    .DEPTH (KON_FIFO_DEPTH),
    .WIDTH (KON_ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (wr_entry),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign avail = ~fifo_empty;
  assign busy  = fifo_full;
`else
  logic       pend_valid;
  kon_entry_t pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend       <= '0;
    end else if (push) begin
      pend_valid <= 1'b1;
      pend       <= wr_entry;
    end else if (pop) begin
      pend_valid <= 1'b0;
    end
  end

  assign avail = pend_valid;
  assign head  = pend;
  // One slot only: refuse while it is occupied or being played out
  assign busy  = (state == KON_HOLD) | pend_valid;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= KON_IDLE;
    else     state <= next_state;
  end

  // Next state: HOLD is only entered from IDLE, which guarantees the low gap
  always_comb begin
    next_state = state;
    case (state)
      KON_IDLE: if (avail)      next_state = KON_HOLD;
      KON_HOLD: if (cnt == '0)  next_state = KON_IDLE;
      default:                  next_state = KON_IDLE;
    endcase
  end

  // Outputs: up_keyon straight from state so reset drops it at once
  always_comb begin
    up_keyon = (state == KON_HOLD);
    pop      = (state == KON_IDLE) & avail;
  end

  // Datapath: address latch, hold counter, latched command, loss pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr     <= '0;
      cnt      <= '0;
      keyon_op <= '0;
      keyon_ch <= '0;
      kon_lost <= 1'b0;
    end else begin
      kon_lost <= kon_wr & busy;
      if (cpu.write & ~cpu.a0) addr <= cpu.din;
      if (pop) begin
        keyon_ch <= head.ch;
        keyon_op <= head.op;
        cnt      <= HOLD_LOAD;
      end else if ((state == KON_HOLD) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jt51_kon_wr.sv
// tb/tb_jt51_kon_wr.sv - directed self-checking bench for jt51_kon_wr
module tb_jt51_kon_wr;

`ifdef JT51_KON_FIFO_EN
  localparam bit FIFO_BUILD = 1'b1;
`else
  localparam bit FIFO_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] keyon_op;
  logic [2:0] keyon_ch;
  logic       up_keyon, busy, kon_lost;
  int         errors = 0;
  int         checks = 0;

  jt51_kon_wr_if bus ();

  jt51_kon_wr #(.HOLD_CYCLES(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu      (bus),
    .keyon_op (keyon_op),
    .keyon_ch (keyon_ch),
    .up_keyon (up_keyon),
    .busy     (busy),
    .kon_lost (kon_lost)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Called at a negedge; strobe is sampled on the next posedge; returns at the following negedge
  task automatic bus_wr(input logic a, input logic [7:0] d);
    bus.write = 1'b1; bus.a0 = a; bus.din = d;
    @(negedge clk);
    bus.write = 1'b0; bus.a0 = 1'b0; bus.din = 8'h00;
  endtask

  // gap = low samples before rise, len = high samples; returns on the first low sample after the pulse
  task automatic measure(output int gap, output int len, output logic [2:0] ch,
                         output logic [3:0] op, output logic stable);
    gap = 0; len = 0; ch = 3'd0; op = 4'd0; stable = 1'b1;
    @(negedge clk);
    while (!up_keyon && gap < 100) begin gap++; @(negedge clk); end
    if (up_keyon) begin
      ch = keyon_ch; op = keyon_op;
      while (up_keyon && len < 100) begin
        len++;
        if (keyon_ch !== ch || keyon_op !== op) stable = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.write = 1'b0; bus.a0 = 1'b0; bus.din = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (up_keyon !== 1'b0) begin errors++; $display("FAIL reset_up_keyon: got %b want 0", up_keyon); end
    checks++; if (keyon_op !== 4'h0) begin errors++; $display("FAIL reset_keyon_op: got %h want 0", keyon_op); end
    checks++; if (keyon_ch !== 3'd0) begin errors++; $display("FAIL reset_keyon_ch: got %0d want 0", keyon_ch); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (kon_lost !== 1'b0) begin errors++; $display("FAIL reset_kon_lost: got %b want 0", kon_lost); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_keyon;
    int g, l; logic [2:0] c; logic [3:0] o; logic s;
    bus_wr(1'b0, 8'h08);
    bus_wr(1'b1, 8'h7A);
    checks++; if (up_keyon !== 1'b0) begin errors++; $display("FAIL keyon_not_yet: got %b want 0", up_keyon); end
    checks++; if (busy !== !FIFO_BUILD) begin errors++; $display("FAIL keyon_busy_pending: got %b want %b", busy, !FIFO_BUILD); end
    measure(g, l, c, o, s);
    checks++; if (g !== 0) begin errors++; $display("FAIL keyon_latency: got %0d want 0", g); end
    checks++; if (l !== 32) begin errors++; $display("FAIL keyon_len: got %0d want 32", l); end
    checks++; if (c !== 3'd2) begin errors++; $display("FAIL keyon_ch: got %0d want 2", c); end
    checks++; if (o !== 4'hF) begin errors++; $display("FAIL keyon_op: got %h want f", o); end
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL keyon_stable: got %b want 1", s); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL keyon_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_other_addr;
    logic seen = 1'b0;
    bus_wr(1'b0, 8'h20);
    bus_wr(1'b1, 8'h5B);
    bus_wr(1'b1, 8'h05);
    for (int i = 0; i < 6; i++) begin
      if (up_keyon || busy || kon_lost) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL other_addr_activity: got %b want 0", seen); end
    bus_wr(1'b0, 8'h08);
  endtask

  task automatic test_lost;
    int hi = 0, g, l; logic [2:0] c; logic [3:0] o; logic s;
    bus_wr(1'b1, 8'h19);                       // ch 1, op 3
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (up_keyon && keyon_ch == 3'd1 && keyon_op == 4'h3) hi++;
    end
    bus_wr(1'b1, 8'h2E);                       // ch 6, op 5, during hold
    checks++; if (kon_lost !== !FIFO_BUILD) begin errors++; $display("FAIL lost_pulse: got %b want %b", kon_lost, !FIFO_BUILD); end
    if (up_keyon && keyon_ch == 3'd1 && keyon_op == 4'h3) hi++;
    @(negedge clk);
    checks++; if (kon_lost !== 1'b0) begin errors++; $display("FAIL lost_pulse_width: got %b want 0", kon_lost); end
    for (int i = 0; i < 60; i++) begin
      if (!up_keyon) break;
      if (keyon_ch == 3'd1 && keyon_op == 4'h3) hi++;
      @(negedge clk);
    end
    checks++; if (hi !== 32) begin errors++; $display("FAIL lost_first_unchanged: got %0d want 32", hi); end
    measure(g, l, c, o, s);
    checks++; if (l !== (FIFO_BUILD ? 32 : 0)) begin errors++; $display("FAIL lost_second_len: got %0d want %0d", l, FIFO_BUILD ? 32 : 0); end
`ifdef JT51_KON_FIFO_EN
    checks++; if ({o, c} !== {4'h5, 3'd6}) begin errors++; $display("FAIL lost_second_cmd: got %h/%0d want 5/6", o, c); end
`endif
  endtask

  task automatic test_hold_exit;
    int g, l; logic [2:0] c; logic [3:0] o; logic s;
    bus_wr(1'b1, 8'h7A);
    repeat (32) @(negedge clk);                // last high sample of the hold
    checks++; if (up_keyon !== 1'b1) begin errors++; $display("FAIL exit_last_high: got %b want 1", up_keyon); end
    bus_wr(1'b1, 8'h05);                       // lands on the exit cycle
    checks++; if (up_keyon !== 1'b0) begin errors++; $display("FAIL exit_gap: got %b want 0", up_keyon); end
    checks++; if (kon_lost !== !FIFO_BUILD) begin errors++; $display("FAIL exit_lost: got %b want %b", kon_lost, !FIFO_BUILD); end
    measure(g, l, c, o, s);
    checks++; if (l !== (FIFO_BUILD ? 32 : 0)) begin errors++; $display("FAIL exit_next_len: got %0d want %0d", l, FIFO_BUILD ? 32 : 0); end
  endtask

  task automatic test_back_to_back;
    int g1, l1, g2, l2, zeros; logic [2:0] c1, c2; logic [3:0] o1, o2; logic s1, s2;
`ifdef JT51_KON_FIFO_EN
    bus_wr(1'b1, 8'h7A);
    bus_wr(1'b1, 8'h05);
    measure(g1, l1, c1, o1, s1);
    measure(g2, l2, c2, o2, s2);
    zeros = 1 + g2;
    checks++; if (zeros !== 1) begin errors++; $display("FAIL b2b_gap: got %0d want 1", zeros); end
`else
    bus_wr(1'b1, 8'h7A);
    measure(g1, l1, c1, o1, s1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_free: got %b want 0", busy); end
    bus_wr(1'b1, 8'h05);
    measure(g2, l2, c2, o2, s2);
    zeros = 2 + g2;
    checks++; if (zeros !== 2) begin errors++; $display("FAIL b2b_gap: got %0d want 2", zeros); end
`endif
    checks++; if (c1 !== 3'd2) begin errors++; $display("FAIL b2b_first_ch: got %0d want 2", c1); end
    checks++; if (l2 !== 32) begin errors++; $display("FAIL b2b_second_len: got %0d want 32", l2); end
    checks++; if (c2 !== 3'd5) begin errors++; $display("FAIL b2b_keyoff_ch: got %0d want 5", c2); end
    checks++; if (o2 !== 4'h0) begin errors++; $display("FAIL b2b_keyoff_op: got %h want 0", o2); end
  endtask

  task automatic test_reset_in_hold;
    int g, l; logic [2:0] c; logic [3:0] o; logic s;
    bus_wr(1'b1, 8'h19);
    bus_wr(1'b1, 8'h2E);
    bus_wr(1'b1, 8'h05);
    repeat (10) @(negedge clk);
    checks++; if (up_keyon !== 1'b1) begin errors++; $display("FAIL rsthold_active: got %b want 1", up_keyon); end
    #2 rst = 1'b1;
    #1;
    checks++; if (up_keyon !== 1'b0) begin errors++; $display("FAIL rsthold_drop: got %b want 0", up_keyon); end
    checks++; if ({keyon_op, keyon_ch} !== 7'd0) begin errors++; $display("FAIL rsthold_cmd: got %h want 0", {keyon_op, keyon_ch}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rsthold_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    measure(g, l, c, o, s);
    checks++; if (l !== 0) begin errors++; $display("FAIL rsthold_pending: got %0d want 0", l); end
    bus_wr(1'b1, 8'h7A);                       // address register cleared by reset
    measure(g, l, c, o, s);
    checks++; if (l !== 0) begin errors++; $display("FAIL rsthold_addr_cleared: got %0d want 0", l); end
    bus_wr(1'b0, 8'h08);
  endtask

`ifdef JT51_KON_FIFO_EN
  task automatic test_fifo_order;
    int g, l; logic [2:0] c; logic [3:0] o; logic s;
    logic [2:0] exp_ch [5] = '{3'd7, 3'd0, 3'd1, 3'd2, 3'd3};
    logic [7:0] d;
    bus_wr(1'b1, 8'h0F);
    for (int i = 0; i < 5; i++) begin
      d = 8'h08 | 8'(i);
      bus_wr(1'b1, d);
    end
    checks++; if (kon_lost !== 1'b1) begin errors++; $display("FAIL fifo_fifth_lost: got %b want 1", kon_lost); end
    @(negedge clk);
    checks++; if (kon_lost !== 1'b0) begin errors++; $display("FAIL fifo_lost_once: got %b want 0", kon_lost); end
    for (int i = 0; i < 5; i++) begin
      measure(g, l, c, o, s);
      checks++; if (c !== exp_ch[i]) begin errors++; $display("FAIL fifo_order_%0d: got ch %0d want %0d", i, c, exp_ch[i]); end
    end
    measure(g, l, c, o, s);
    checks++; if (l !== 0) begin errors++; $display("FAIL fifo_drained: got %0d want 0", l); end
  endtask
`endif

  initial begin
    test_reset;
    test_keyon;
    test_other_addr;
    test_lost;
    test_hold_exit;
    test_back_to_back;
    test_reset_in_hold;
`ifdef JT51_KON_FIFO_EN
    test_fifo_order;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jt51_kon_wr.md
JT51_KON_WR -- requirements
Module: jt51_kon_wr

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 32, meaning the number of clk cycles up_keyon stays high per key-on update (one full 32-slot operator sweep).
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port write, input, 1, CPU bus write strobe, one cycle per access.
REQ-005 SHALL have port a0, input, 1, 0 = address write, 1 = data write.
REQ-006 SHALL have port din, input, 8, CPU bus data.
REQ-007 SHALL have port keyon_op, output, 4, operator mask: bit0 M1, bit1 C1, bit2 M2, bit3 C2.
REQ-008 SHALL have port keyon_ch, output, 3, target channel.
REQ-009 SHALL have port up_keyon, output, 1, update request to the key-on tracker.
REQ-010 SHALL have port busy, output, 1, no further key-on write can be accepted.
REQ-011 SHALL have port kon_lost, output, 1, one-cycle pulse when a key-on write is dropped.

Function
REQ-012 SHALL latch din into an 8-bit address register on write && !a0.
REQ-013 SHALL treat write && a0 with address register == 8'h08 as a key-on write: ch = din[2:0], op = din[6:3]; din[7] is ignored.
REQ-014 SHALL ignore data writes to any other address.
REQ-015 SHALL use two states: IDLE and HOLD.
REQ-016 In IDLE with an entry available, SHALL load keyon_ch/keyon_op, raise up_keyon on the next cycle, and enter HOLD.
REQ-017 In HOLD, SHALL keep up_keyon, keyon_ch and keyon_op stable for exactly HOLD_CYCLES cycles, counted by a 5-bit down-counter.
REQ-018 At counter 0, SHALL drop up_keyon for at least one cycle and return to IDLE; the next entry starts after that gap.
REQ-019 A new accepted write SHALL never alter keyon_ch or keyon_op while in HOLD.
REQ-020 A key-on write while busy=1 SHALL be dropped and SHALL pulse kon_lost on the following cycle.
REQ-021 A write in the same cycle as HOLD exit SHALL be judged against busy as it is in that cycle.
REQ-022 An all-zero op mask SHALL be a valid key-off update and SHALL be handled like any other entry.

Reset
REQ-023 On rst, SHALL clear the address register to 0, set the state to IDLE, clear the counter, and drive up_keyon=0, keyon_op=0, keyon_ch=0, busy=0, kon_lost=0.
REQ-024 Reset asserted during HOLD SHALL drop up_keyon immediately and discard all pending entries.

Configuration
REQ-025 With JT51_KON_FIFO_EN defined, accepted writes SHALL queue in a 4-entry FIFO of 7-bit {op,ch} entries, served in order; busy = FIFO full.
REQ-026 Without JT51_KON_FIFO_EN, SHALL hold a single pending entry; busy = (state==HOLD) or an entry is pending.
REQ-027 In both builds, a simultaneous FIFO push and pop SHALL be allowed when not full.

Structure
REQ-028 The constants KON_REG_ADDR (8'h08) and the HOLD_CYCLES default SHALL live in a shared jt51 package/include.
REQ-029 The FIFO SHALL be the sub-module jt51_kon_fifo (parameter depth and width, full and empty flags), instantiated only under JT51_KON_FIFO_EN.

Verification
REQ-030 Address 0x08 then data 0x7A -> up_keyon high for 32 cycles with keyon_ch=2 and keyon_op=4'hF, then low.
REQ-031 Data 0x5B written to address 0x20 -> up_keyon stays 0 and no state change.
REQ-032 FIFO build: five back-to-back key-on writes (ch 0..4) during a hold -> ch 0,1,2,3 served in order, the fifth drops, kon_lost pulses once.
REQ-033 Non-FIFO build: second write during HOLD -> kon_lost pulses; first update is unchanged for the full 32 cycles.
REQ-034 rst asserted at cycle 10 of HOLD -> up_keyon=0 at once; after release, nothing is pending.
REQ-035 Back-to-back updates -> at least one up_keyon=0 cycle between them; data 0x05 gives keyon_op=0, keyon_ch=5.
